ifill_responder: RTL

Memory-side responder for L1 instruction-cache line fills. It accepts a line-fill request from the I-cache, which is the initiator. It then reads BLOCKS consecutive words from a fixed-latency synchronous instruction memory and returns them as a beat stream. Delivery is critical-word-first with wrap-around inside the line. It sits between the I-cache miss path and the instruction memory, and is instantiated only when RV_ICACHE_ON=1.

---
 rtl/ifill_responder_pkg.sv | 23 ++
 rtl/ifill_rsp_fifo.sv | 48 ++++
 rtl/ifill_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ifill_responder_pkg.sv
// Shared configuration, FSM encoding and request/beat types for the I-cache line-fill responder.
package ifill_responder_pkg;
  localparam int unsigned CFG_ADDR_WIDTH = 32;
  localparam int unsigned CFG_DATA_WIDTH = 32;
  localparam int unsigned CFG_BLOCKS     = 4;
  localparam int unsigned IDX_WIDTH      = $clog2(CFG_BLOCKS);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  typedef struct packed {
    logic [CFG_ADDR_WIDTH-1:0] addr;
  } req_t;

  typedef struct packed {
    logic [CFG_DATA_WIDTH-1:0] data;
    logic [IDX_WIDTH-1:0]      index;
    logic                      last;
  } beat_t;

  function automatic logic [CFG_ADDR_WIDTH-1:0] line_base(input logic [CFG_ADDR_WIDTH-1:0] addr);
    return addr & ~CFG_ADDR_WIDTH'(CFG_BLOCKS * 4 - 1);
  endfunction
endpackage

// File: rtl/ifill_rsp_fifo.sv
// Show-ahead response FIFO: the head entry is visible on rdata whenever the FIFO is not empty.
module ifill_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type beat_t = logic,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             push,
  input  beat_t            wdata,
  input  logic             pop,
  output beat_t            rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  beat_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/ifill_responder.sv
// Critical-word-first I-cache line-fill responder in front of a fixed-latency instruction memory.
// BLOCKS and DATA_WIDTH must match the package configuration that sizes beat_t.
//   state    | meaning
//   ST_IDLE  | ready for a line-fill request
//   ST_ISSUE | issuing the BLOCKS word reads, gated by FIFO credit
//   ST_DRAIN | all reads issued, waiting for the last beat to be accepted
module ifill_responder
  import ifill_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = CFG_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = CFG_DATA_WIDTH,
  parameter int unsigned BLOCKS      = CFG_BLOCKS,
  parameter int unsigned MEM_LATENCY = 1,
  localparam int unsigned IDX_W      = $clog2(BLOCKS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  o_req_ready,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [IDX_W-1:0]      o_rsp_index,
  output logic                  o_rsp_last,
  input  logic                  i_rsp_ready,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);
  localparam int unsigned FIFO_DEPTH = MEM_LATENCY + 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  state_t                 state_q, state_d;
  req_t                   req;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [IDX_W-1:0]       start_q, rd_cnt_q, ret_cnt_q, rd_idx;
  logic [MEM_LATENCY-1:0] inflight_q;
  logic [CNT_W-1:0]       inflight_cnt, fifo_count;
  logic [CNT_W:0]         credit_used;
  logic                   req_fire, credit_ok, mem_rd, push, pop, fifo_empty, fifo_full;
  beat_t                  push_beat, head;

  assign req.addr    = i_req_addr;
  assign req_fire    = (state_q == ST_IDLE) && i_req_valid && !i_reset;
  assign o_req_ready = (state_q == ST_IDLE) && !i_reset;
  assign o_busy      = (state_q != ST_IDLE);

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(MEM_LATENCY); i++) inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
  end

  // A pop in the same cycle frees its slot, which keeps beats back-to-back without backpressure.
  assign pop         = o_rsp_valid && i_rsp_ready;
  assign credit_used = (CNT_W+1)'(inflight_cnt) + (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop);
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    state_d = state_q;
    mem_rd  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (req_fire) state_d = ST_ISSUE;
      ST_ISSUE: begin
        mem_rd = credit_ok;
        if (credit_ok && (rd_cnt_q == IDX_W'(BLOCKS - 1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (pop && head.last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      start_q    <= '0;
      rd_cnt_q   <= '0;
      ret_cnt_q  <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= (inflight_q << 1) | MEM_LATENCY'(mem_rd);
      if (req_fire) begin
        base_q    <= line_base(req.addr);
        start_q   <= req.addr[IDX_W+1:2];
        rd_cnt_q  <= '0;
        ret_cnt_q <= '0;
      end else begin
        if (mem_rd) rd_cnt_q  <= rd_cnt_q + IDX_W'(1);
        if (push)   ret_cnt_q <= ret_cnt_q + IDX_W'(1);
      end
    end
  end

  // Index arithmetic is IDX_W wide so the wrap stays inside the line.
  assign rd_idx     = start_q + rd_cnt_q;
  assign o_mem_rd   = mem_rd;
  assign o_mem_addr = mem_rd ? (base_q + (ADDR_WIDTH'(rd_idx) << 2)) : '0;

  assign push = inflight_q[MEM_LATENCY-1];
  always_comb begin
    push_beat       = '0;
    push_beat.data  = i_mem_rdata;
    push_beat.index = start_q + ret_cnt_q;
    push_beat.last  = (ret_cnt_q == IDX_W'(BLOCKS - 1));
  end

  ifill_rsp_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .beat_t (beat_t)
  ) u_rsp_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .push    (push),
    .wdata   (push_beat),
    .pop     (pop),
    .rdata   (head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign o_rsp_valid = !fifo_empty;
  assign o_rsp_data  = o_rsp_valid ? head.data  : '0;
  assign o_rsp_index = o_rsp_valid ? head.index : '0;
  assign o_rsp_last  = o_rsp_valid && head.last;

  assert property (@(posedge i_clock) disable iff (i_reset) !(push && fifo_full && !pop))
    else $error("ifill_responder: response FIFO overflow");
endmodule
